pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Top-level game state machine for Pong. Owns each player's remaining lives, the serve/pause timer and the game phase.
- Drives the lives counts and display-select flags consumed by the on-screen text renderer. Drives the freeze/serve controls consumed by the ball/paddle graphics stage.
- Sits between the debounced buttons, the graphics miss detector and the text/graphics renderers.

Parameters:
- LIVES_INIT, 3, lives loaded per player at game start (1..3; fits 2 bits).
- TIMER_TICKS, 120, frame ticks of pause after a miss and after game over (2 s at 60 Hz; 1..127).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- tick_60hz  in  1  one-cycle pulse at start of vertical blank
- btn  in  2  debounced player buttons (any 1 = press)
- miss1  in  1  one-cycle pulse: ball passed player1's paddle
- miss2  in  1  one-cycle pulse: ball passed player2's paddle
- ball1  out  2  player1 remaining lives
- ball2  out  2  player2 remaining lives
- gra_still  out  1  1 = graphics freeze the ball at the serve position
- serve  out  1  one-cycle pulse: graphics relaunch the ball
- show_title  out  1  1 = logo and rules text enabled
- game_over  out  1  1 = winner text enabled
- winner  out  2  01 = player1, 10 = player2, 11 = draw, 00 = none
- state_dbg  out  2  current state encoding

Behaviour:
Reset values:
- state NEWGAME; ball1 = ball2 = LIVES_INIT; timer 0; gra_still 1; serve 0; show_title 1; game_over 0; winner 00.

Button handling:
- press = rising edge of (btn[0] | btn[1]), using a 1-flop history register (reset 0).
- A held button never generates a second press.

States and transitions (encoding NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3):
- NEWGAME: lives held at LIVES_INIT, gra_still 1, show_title 1. On press -> PLAY, and serve pulses in the same cycle as the transition register update (registered, visible the cycle after the press).
- PLAY: gra_still 0, show_title 0. On miss1: ball1 -= 1. On miss2: ball2 -= 1. Both may occur in the same cycle; both decrement.
  - If any life count becomes 0 -> OVER.
  - Otherwise, on any miss -> NEWBALL, with timer loaded to TIMER_TICKS.
- NEWBALL: gra_still 1. timer decrements on each tick_60hz while nonzero. When timer == 0 and press -> PLAY with a serve pulse. A press while timer != 0 is ignored (edge consumed).
- OVER: game_over 1, gra_still 1. Timer is loaded to TIMER_TICKS on entry. When timer reaches 0 -> NEWGAME, which reloads lives.

Winner:
- Registered on entry to OVER: ball2==0 && ball1!=0 -> 01; ball1==0 && ball2!=0 -> 10; both 0 -> 11.
- Holds through OVER; cleared to 00 in NEWGAME.

Arithmetic and boundaries:
- Lives are 2-bit and decrement saturates at 0; no wrap to 3.
- Timer is 7-bit and never wraps below 0.
- miss1/miss2 are ignored outside PLAY.
- tick_60hz coincident with state entry: the load takes priority over the decrement.

Outputs and reset:
- All outputs are registered, except state_dbg, which is the state register directly.
- Reset asserted mid-game returns immediately (asynchronously) to the reset values.

Decomposition:
- Shared package pong_pkg: state enum (NEWGAME, PLAY, NEWBALL, OVER), LIVES_W=2, TIMER_W=7, winner codes.
- One natural sub-module: pong_frame_timer (loadable down-counter, load/tick inputs, done output), reusable by the graphics stage.

Test Plan:
1. Reset, then press btn[0] -> PLAY next cycle; serve=1 for exactly 1 cycle; gra_still=0; ball1=ball2=3; show_title=0.
2. In PLAY, pulse miss1 -> ball1=2, state NEWBALL, gra_still=1. Press before 120 ticks -> still NEWBALL. Press after tick 120 -> PLAY with serve.
3. Three miss2 pulses separated by serves -> ball2 3->2->1->0; OVER; game_over=1; winner=01. After 120 ticks -> NEWGAME, ball1=ball2=3, winner=00.
4. ball1=1, ball2=1, miss1 and miss2 in the same cycle -> both 0; OVER; winner=11.
5. Hold btn high across the NEWGAME->PLAY->miss->NEWBALL timeout -> no second serve until btn released and re-pressed.
6. Drop rst_n low during NEWBALL with timer=50 -> outputs return to reset values with no clock edge; after release, state NEWGAME.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game controller and graphics stages.
package pong_pkg;

    localparam int unsigned LIVES_W = 2;
    localparam int unsigned TIMER_W = 7;

    typedef enum logic [1:0] {
        StNewGame = 2'd0,
        StPlay    = 2'd1,
        StNewBall = 2'd2,
        StOver    = 2'd3
    } pong_state_e;

    localparam logic [1:0] WinNone = 2'b00;
    localparam logic [1:0] WinP1   = 2'b01;
    localparam logic [1:0] WinP2   = 2'b10;
    localparam logic [1:0] WinDraw = 2'b11;

endpackage

// File: rtl/pong_frame_timer.sv
// Loadable frame-tick down-counter; stops at zero, load wins over a coincident tick.
module pong_frame_timer
    import pong_pkg::*;
#(
    parameter int unsigned Width = TIMER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             tick_i,
    output logic [Width-1:0] count_o,
    output logic             done_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game phase FSM: lives, serve/pause timing, winner and renderer display flags.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned TIMER_TICKS = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_60hz_i,
    input  logic [1:0]         btn_i,
    input  logic               miss1_i,
    input  logic               miss2_i,
    output logic [LIVES_W-1:0] ball1_o,
    output logic [LIVES_W-1:0] ball2_o,
    output logic               gra_still_o,
    output logic               serve_o,
    output logic               show_title_o,
    output logic               game_over_o,
    output logic [1:0]         winner_o,
    output logic [1:0]         state_dbg_o
);

    localparam logic [LIVES_W-1:0] LivesInit  = LIVES_W'(LIVES_INIT);
    localparam logic [TIMER_W-1:0] TimerTicks = TIMER_W'(TIMER_TICKS);

    pong_state_e        state_d, state_q;
    logic               btn_q;
    logic [LIVES_W-1:0] ball1_d, ball1_q, ball2_d, ball2_q;
    logic [1:0]         winner_d, winner_q;
    logic               serve_d, serve_q;
    logic               gra_still_q, show_title_q, game_over_q;
    logic               press;
    logic               timer_load, timer_done;
    logic [LIVES_W-1:0] ball1_dec, ball2_dec;
    logic [TIMER_W-1:0] timer_count;

    pong_frame_timer #(
        .Width (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (TimerTicks),
        .tick_i     (tick_60hz_i),
        .count_o    (timer_count),
        .done_o     (timer_done)
    );

    assign press     = (|btn_i) & ~btn_q;
    assign ball1_dec = (miss1_i && (ball1_q != '0)) ? ball1_q - LIVES_W'(1) : ball1_q;
    assign ball2_dec = (miss2_i && (ball2_q != '0)) ? ball2_q - LIVES_W'(1) : ball2_q;

    always_comb begin
        state_d    = state_q;
        ball1_d    = ball1_q;
        ball2_d    = ball2_q;
        winner_d   = winner_q;
        serve_d    = 1'b0;
        timer_load = 1'b0;
        unique case (state_q)
            StNewGame: begin
                if (press) begin
                    state_d = StPlay;
                    serve_d = 1'b1;
                end
            end
            StPlay: begin
                ball1_d = ball1_dec;
                ball2_d = ball2_dec;
                if ((ball1_dec == '0) || (ball2_dec == '0)) begin
                    state_d    = StOver;
                    timer_load = 1'b1;
                    // Bit 0 flags player1 winning, bit 1 player2; both set is a draw.
                    winner_d   = {ball1_dec == '0, ball2_dec == '0};
                end else if (miss1_i || miss2_i) begin
                    state_d    = StNewBall;
                    timer_load = 1'b1;
                end
            end
            StNewBall: begin
                if (timer_done && press) begin
                    state_d = StPlay;
                    serve_d = 1'b1;
                end
            end
            StOver: begin
                if (timer_done) begin
                    state_d = StNewGame;
                end
            end
        endcase
        if (state_d == StNewGame) begin
            ball1_d  = LivesInit;
            ball2_d  = LivesInit;
            winner_d = WinNone;
        end
    end

    // Display flags are derived from the next state so they change with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StNewGame;
            btn_q        <= 1'b0;
            ball1_q      <= LivesInit;
            ball2_q      <= LivesInit;
            winner_q     <= WinNone;
            serve_q      <= 1'b0;
            gra_still_q  <= 1'b1;
            show_title_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= |btn_i;
            ball1_q      <= ball1_d;
            ball2_q      <= ball2_d;
            winner_q     <= winner_d;
            serve_q      <= serve_d;
            gra_still_q  <= (state_d != StPlay);
            show_title_q <= (state_d == StNewGame);
            game_over_q  <= (state_d == StOver);
        end
    end

    assign ball1_o      = ball1_q;
    assign ball2_o      = ball2_q;
    assign winner_o     = winner_q;
    assign serve_o      = serve_q;
    assign gra_still_o  = gra_still_q;
    assign show_title_o = show_title_q;
    assign game_over_o  = game_over_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed and randomized bench for pong_game_ctrl against a cycle-level game model.
module tb_pong_game_ctrl;

    localparam int LIVES = 3;
    localparam int TICKS = 120;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       miss1 = 1'b0;
    logic       miss2 = 1'b0;
    logic [1:0] ball1, ball2, winner, state_dbg;
    logic       gra_still, serve, show_title, game_over;

    int checks = 0;
    int failures = 0;

    // Model of the game: phase 0 new game, 1 play, 2 new ball, 3 over.
    int m_phase, m_b1, m_b2, m_timer, m_winner, m_serve;
    bit m_hist;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .LIVES_INIT  (LIVES),
        .TIMER_TICKS (TICKS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_60hz_i  (tick),
        .btn_i        (btn),
        .miss1_i      (miss1),
        .miss2_i      (miss2),
        .ball1_o      (ball1),
        .ball2_o      (ball2),
        .gra_still_o  (gra_still),
        .serve_o      (serve),
        .show_title_o (show_title),
        .game_over_o  (game_over),
        .winner_o     (winner),
        .state_dbg_o  (state_dbg)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_b1 = LIVES; m_b2 = LIVES; m_timer = 0;
        m_winner = 0; m_serve = 0; m_hist = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] b, input logic t, input logic m1, input logic m2);
        bit press;
        bit load;
        int old_t;
        press   = (b != 2'b00) && !m_hist;
        m_hist  = (b != 2'b00);
        m_serve = 0;
        load    = 1'b0;
        old_t   = m_timer;
        case (m_phase)
            0: if (press) begin m_phase = 1; m_serve = 1; end
            1: begin
                if (m1 && m_b1 > 0) m_b1--;
                if (m2 && m_b2 > 0) m_b2--;
                if (m_b1 == 0 || m_b2 == 0) begin
                    m_phase = 3; load = 1'b1;
                    if (m_b1 == 0 && m_b2 == 0) m_winner = 3;
                    else if (m_b2 == 0) m_winner = 1;
                    else m_winner = 2;
                end else if (m1 || m2) begin
                    m_phase = 2; load = 1'b1;
                end
            end
            2: if (old_t == 0 && press) begin m_phase = 1; m_serve = 1; end
            default: if (old_t == 0) begin
                m_phase = 0; m_b1 = LIVES; m_b2 = LIVES; m_winner = 0;
            end
        endcase
        if (load) m_timer = TICKS;
        else if (t && old_t > 0) m_timer = old_t - 1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, int'(state_dbg), m_phase);
        check({tag, ".ball1"}, int'(ball1), m_b1);
        check({tag, ".ball2"}, int'(ball2), m_b2);
        check({tag, ".serve"}, int'(serve), m_serve);
        check({tag, ".winner"}, int'(winner), m_winner);
        check({tag, ".gra_still"}, int'(gra_still), (m_phase != 1) ? 1 : 0);
        check({tag, ".show_title"}, int'(show_title), (m_phase == 0) ? 1 : 0);
        check({tag, ".game_over"}, int'(game_over), (m_phase == 3) ? 1 : 0);
    endtask

    task automatic step(input logic [1:0] b, input logic t, input logic m1, input logic m2);
        btn = b; tick = t; miss1 = m1; miss2 = m2;
        @(posedge clk);
        model_step(b, t, m1, m2);
        #1;
        check_all("cyc");
    endtask

    task automatic run_ticks(input logic [1:0] b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'(i % 2), 1'b0, 1'b0);
    endtask

    task automatic wait_zero(input logic [1:0] b);
        for (int i = 0; i < 2 * TICKS + 10 && m_timer != 0; i++) step(b, 1'b1, 1'b0, 1'b0);
    endtask

    // Release, press and release again to serve from NEWBALL or NEWGAME.
    task automatic serve_ball();
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic miss_and_serve(input logic m1, input logic m2);
        step(2'b00, 1'b0, m1, m2);
        wait_zero(2'b00);
        serve_ball();
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        check_all("reset");
        rst_n = 1'b1;

        // Start a game
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        check("t1_state", int'(state_dbg), 1);
        check("t1_serve", int'(serve), 1);
        check("t1_gra_still", int'(gra_still), 0);
        check("t1_show_title", int'(show_title), 0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        check("t1_serve_once", int'(serve), 0);

        // Miss, early press ignored, press after timeout serves
        step(2'b00, 1'b0, 1'b1, 1'b0);
        check("t2_ball1", int'(ball1), 2);
        check("t2_state", int'(state_dbg), 2);
        run_ticks(2'b00, 20);
        step(2'b10, 1'b0, 1'b0, 1'b0);
        check("t2_early_press", int'(state_dbg), 2);
        wait_zero(2'b00);
        serve_ball();
        check("t2_replay", int'(state_dbg), 1);

        // Player2 loses all lives
        miss_and_serve(1'b0, 1'b1);
        miss_and_serve(1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        check("t3_over", int'(state_dbg), 3);
        check("t3_game_over", int'(game_over), 1);
        check("t3_winner", int'(winner), 1);
        wait_zero(2'b00);
        step(2'b00, 1'b0, 1'b1, 1'b1);
        check("t3_newgame", int'(state_dbg), 0);
        check("t3_lives", int'(ball1), 3);
        check("t3_winner_clr", int'(winner), 0);

        // Simultaneous last misses give a draw
        serve_ball();
        miss_and_serve(1'b1, 1'b0);
        miss_and_serve(1'b0, 1'b1);
        miss_and_serve(1'b1, 1'b0);
        miss_and_serve(1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1, 1'b1);
        check("t4_ball1", int'(ball1), 0);
        check("t4_ball2", int'(ball2), 0);
        check("t4_winner", int'(winner), 3);
        wait_zero(2'b00);
        step(2'b00, 1'b0, 1'b0, 1'b0);

        // Held button never re-serves
        step(2'b11, 1'b0, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b1, 1'b0);
        wait_zero(2'b11);
        run_ticks(2'b01, 6);
        check("t5_held", int'(state_dbg), 2);
        serve_ball();
        check("t5_repress", int'(state_dbg), 1);

        // Asynchronous reset mid-pause
        step(2'b00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && m_timer > 50; i++) step(2'b00, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_state", int'(state_dbg), 0);
        check("t6_gra_still", int'(gra_still), 1);
        check_all("t6");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        check("t6_after", int'(state_dbg), 0);

        // Random play
        for (int i = 0; i < 6000; i++) begin
            logic [1:0] b;
            b = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : btn;
            step(b, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
